// File: rtl/drag_tree_ctrl.sv
// Multi-lane drag race light tree: staging, sportsman/pro amber countdown, fouls and winner pick.
// Define DRAG_REACTION_TIMER_EN to build the per-lane reaction-time counters on ReactTime.
module drag_tree_ctrl #(
  parameter int LANES       = 2,
  parameter int AMBERS      = 3,
  parameter int TICK_DIV    = 5000000,
  parameter int STAGE_TICKS = 5,
  parameter int AMBER_TICKS = 5,
  parameter int PRO_TICKS   = 4,
  parameter int RT_W        = 16
) (
  input  logic                    Clock,
  input  logic                    Rst,
  input  logic                    Mode,
  input  logic [LANES-1:0]        PSB,
  input  logic [LANES-1:0]        SB,
  output logic [LANES-1:0]        PSL,
  output logic [LANES-1:0]        SL,
  output logic [LANES*AMBERS-1:0] Amber,
  output logic [LANES-1:0]        G,
  output logic [LANES-1:0]        R,
  output logic [LANES-1:0]        Winner,
  output logic                    RaceDone,
  output logic [LANES*RT_W-1:0]   ReactTime
);

  localparam int MAX_AP = (AMBER_TICKS > PRO_TICKS) ? AMBER_TICKS : PRO_TICKS;
  localparam int MAXT   = (STAGE_TICKS > MAX_AP) ? STAGE_TICKS : MAX_AP;
  localparam int CNT_W  = $clog2(MAXT + 1);
  localparam int PRE_W  = $clog2(TICK_DIV + 1);
  localparam int AMB_W  = $clog2(AMBERS + 1);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_TICKS - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_TICKS - 1);
  localparam logic [CNT_W-1:0] PRO_LAST   = CNT_W'(PRO_TICKS - 1);
  localparam logic [AMB_W-1:0] AMB_LAST   = AMB_W'(AMBERS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_STAGING, S_COUNTDOWN, S_GO, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [LANES-1:0]         psb_meta_q, psb_sync_q, sb_meta_q, sb_sync_q, sb_prev_q;
  logic [PRE_W-1:0]         pre_q, pre_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [AMB_W-1:0]         amb_q, amb_d;
  logic                     mode_q, mode_d;
  logic [LANES-1:0]         foul_q, foul_d, launched_q, launched_d, winner_q, winner_d;
  logic [LANES-1:0]         psl_q, psl_d, sl_q, sl_d, g_q, g_d, r_q, r_d;
  logic [LANES*AMBERS-1:0]  amber_q, amber_d;
  logic                     done_q, done_d;

  logic                     tick, amb_step;
  logic [LANES-1:0]         fall, launch_now, win_pick;
  logic [CNT_W-1:0]         phase_last;

  assign tick       = (pre_q == PRE_LAST);
  assign fall       = sb_prev_q & ~sb_sync_q;
  assign launch_now = (state_q == S_GO) ? (fall & ~foul_q & ~launched_q) : '0;
  // Isolate the lowest set bit so a same-cycle tie goes to the lowest lane.
  assign win_pick   = launch_now & (~launch_now + LANES'(1));
  assign phase_last = mode_q ? PRO_LAST : AMBER_LAST;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      psb_meta_q <= '0;
      psb_sync_q <= '0;
      sb_meta_q  <= '0;
      sb_sync_q  <= '0;
      sb_prev_q  <= '0;
      state_q    <= S_IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      amb_q      <= '0;
      mode_q     <= 1'b0;
      foul_q     <= '0;
      launched_q <= '0;
      winner_q   <= '0;
      psl_q      <= '0;
      sl_q       <= '0;
      amber_q    <= '0;
      g_q        <= '0;
      r_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      psb_meta_q <= PSB;
      psb_sync_q <= psb_meta_q;
      sb_meta_q  <= SB;
      sb_sync_q  <= sb_meta_q;
      sb_prev_q  <= sb_sync_q;
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      amb_q      <= amb_d;
      mode_q     <= mode_d;
      foul_q     <= foul_d;
      launched_q <= launched_d;
      winner_q   <= winner_d;
      psl_q      <= psl_d;
      sl_q       <= sl_d;
      amber_q    <= amber_d;
      g_q        <= g_d;
      r_q        <= r_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    amb_d      = amb_q;
    mode_d     = mode_q;
    foul_d     = foul_q;
    launched_d = launched_q;
    winner_d   = winner_q;
    amb_step   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (&sb_sync_q) begin
          state_d = S_STAGING;
          mode_d  = Mode;
          cnt_d   = '0;
        end
      end
      S_STAGING: begin
        if (!(&sb_sync_q)) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (cnt_q == STAGE_LAST) begin
            state_d = S_COUNTDOWN;
            cnt_d   = '0;
            amb_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COUNTDOWN: begin
        foul_d = foul_q | fall;
        if (&foul_d) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (cnt_q == phase_last) begin
            cnt_d = '0;
            if (mode_q || amb_q == AMB_LAST) begin
              state_d = S_GO;
            end else begin
              amb_d    = amb_q + AMB_W'(1);
              amb_step = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GO: begin
        launched_d = launched_q | launch_now;
        if (winner_q == '0 && launch_now != '0) winner_d = win_pick;
        if (&(launched_d | foul_q)) state_d = S_DONE;
      end
      S_DONE: begin
        if (psb_sync_q == '0 && sb_sync_q == '0) begin
          state_d    = S_IDLE;
          foul_d     = '0;
          launched_d = '0;
          winner_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pre_d = (state_d != state_q || amb_step || tick) ? '0 : pre_q + PRE_W'(1);
  end

  // Lights are registered from the current state, so they follow a transition by one cycle.
  always_comb begin
    psl_d   = '0;
    sl_d    = '0;
    amber_d = '0;
    g_d     = '0;
    r_d     = foul_d;
    done_d  = (state_q == S_DONE) && (state_d == S_DONE);
    if (state_q inside {S_IDLE, S_STAGING, S_COUNTDOWN}) begin
      psl_d = psb_sync_q;
      sl_d  = sb_sync_q;
    end
    if (state_q == S_COUNTDOWN) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < AMBERS; k++) begin
          amber_d[l*AMBERS+k] = !foul_d[l] && (mode_q || amb_q == AMB_W'(k));
        end
      end
    end
    if (state_q == S_GO) g_d = ~foul_d & ~launched_d;
  end

  assign PSL      = psl_q;
  assign SL       = sl_q;
  assign Amber    = amber_q;
  assign G        = g_q;
  assign R        = r_q;
  assign Winner   = winner_q;
  assign RaceDone = done_q;

`ifdef DRAG_REACTION_TIMER_EN
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rt
      logic [RT_W-1:0] rt_q, rt_d;

      always_comb begin
        rt_d = rt_q;
        if (state_q == S_DONE && state_d == S_IDLE) begin
          rt_d = '0;
        end else if (foul_d[gi]) begin
          rt_d = '1;
        end else if (state_q == S_GO && tick && !launched_d[gi] && rt_q != '1) begin
          rt_d = rt_q + RT_W'(1);
        end
      end

      always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) rt_q <= '0;
        else     rt_q <= rt_d;
      end

      assign ReactTime[gi*RT_W +: RT_W] = rt_q;
    end
  endgenerate
`else
  assign ReactTime = '0;
`endif

endmodule

// File: tb/tb_drag_tree_ctrl.sv
// Scoreboard bench for drag_tree_ctrl: stimulus queues expected light snapshots,
// a monitor pops one per observed change of the light outputs and checks hold times.
module tb_drag_tree_ctrl;

  localparam int LANES = 2, AMBERS = 3, TICK_DIV = 4;
  localparam int STAGE_TICKS = 3, AMBER_TICKS = 2, PRO_TICKS = 2, RT_W = 16;
`ifdef DRAG_REACTION_TIMER_EN
  localparam bit RT_ON = 1'b1;
`else
  localparam bit RT_ON = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Rst, Mode;
  logic [1:0]  PSB, SB;
  logic [1:0]  PSL, SL, G, R, Winner;
  logic [5:0]  Amber;
  logic        RaceDone;
  logic [31:0] ReactTime;

  typedef struct {
    logic [5:0]  amber;
    logic [1:0]  g;
    logic [1:0]  r;
    logic [1:0]  w;
    logic        done;
    bit          chk_rt;
    logic [31:0] rt;
    int          dur;
  } snap_t;

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  drag_tree_ctrl #(
    .LANES(LANES), .AMBERS(AMBERS), .TICK_DIV(TICK_DIV), .STAGE_TICKS(STAGE_TICKS),
    .AMBER_TICKS(AMBER_TICKS), .PRO_TICKS(PRO_TICKS), .RT_W(RT_W)
  ) dut (
    .Clock(Clock), .Rst(Rst), .Mode(Mode), .PSB(PSB), .SB(SB),
    .PSL(PSL), .SL(SL), .Amber(Amber), .G(G), .R(R), .Winner(Winner),
    .RaceDone(RaceDone), .ReactTime(ReactTime)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] rtv(input int l1, input int l0);
    if (!RT_ON) return 32'd0;
    return {l1[15:0], l0[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [1:0] g, input logic [1:0] r,
                      input logic [1:0] w, input logic d, input bit c,
                      input logic [31:0] rt, input int dur);
    snap_t s;
    s.amber = a; s.g = g; s.r = r; s.w = w; s.done = d;
    s.chk_rt = c; s.rt = rt; s.dur = dur;
    exp_q.push_back(s);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_lights(input logic [5:0] a, input logic [1:0] g, input string name);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(Amber === a && G === g) && n < 400);
    if (!(Amber === a && G === g)) begin
      tests++; fails++;
      $display("FAIL timeout_%s: amber=%b g=%b, expected amber=%b g=%b", name, Amber, G, a, g);
    end
  endtask

  task automatic wait_done(input logic v);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (RaceDone !== v && n < 400);
    if (RaceDone !== v) begin
      tests++; fails++;
      $display("FAIL timeout_racedone: got %b, expected %b", RaceDone, v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_amber"}, {26'd0, Amber}, 32'd0);
    chk({tag, "_g_r"}, {28'd0, G, R}, 32'd0);
    chk({tag, "_winner_done"}, {29'd0, Winner, RaceDone}, 32'd0);
    chk({tag, "_psl_sl"}, {28'd0, PSL, SL}, 32'd0);
    chk({tag, "_react"}, ReactTime, 32'd0);
  endtask

  initial begin : monitor
    logic [12:0] prev, cur;
    int          hold;
    snap_t       e;
    prev = '0;
    hold = 0;
    forever begin
      @(negedge Clock);
      cur = {Amber, G, R, Winner, RaceDone};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_change: got %b, expected no change from %b", cur, prev);
        end else begin
          e = exp_q.pop_front();
          chk("amber", {26'd0, Amber}, {26'd0, e.amber});
          chk("green", {30'd0, G}, {30'd0, e.g});
          chk("red", {30'd0, R}, {30'd0, e.r});
          chk("winner", {30'd0, Winner}, {30'd0, e.w});
          chk("race_done", {31'd0, RaceDone}, {31'd0, e.done});
          if (e.dur != 0) chk("hold_cycles", hold, e.dur);
          if (e.chk_rt) chk("react_time", ReactTime, e.rt);
          $display("[TB] snapshot amber=%b g=%b r=%b winner=%b done=%b rt=%h prev_held=%0d",
                   Amber, G, R, Winner, RaceDone, ReactTime, hold);
        end
        hold = 1;
        prev = cur;
      end else begin
        hold++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    Rst = 1'b1; Mode = 1'b0; PSB = 2'b00; SB = 2'b00;
    #1;
    chk_all_zero("por");
    skip(3);
    Rst = 1'b0;
    skip(3);

    // Sportsman: lane 1 launches 5 ticks into green, lane 0 at 7 ticks.
    push(6'b001001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b010010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b100100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b000000, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, rtv(5, 7), 1);
    push(6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 0);
    Mode = 1'b0; PSB = 2'b11; SB = 2'b11;
    wait_lights(6'b000000, 2'b11, "sport_green");
    skip(18); SB[1] = 1'b0;
    skip(9);  SB[0] = 1'b0;
    wait_done(1'b1);
    PSB = 2'b00;
    wait_done(1'b0);
    skip(4);

    // Pro: all ambers together, then a same-cycle launch of both lanes.
    push(6'b111111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b000000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, rtv(2, 2), 1);
    push(6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 0);
    Mode = 1'b1; PSB = 2'b11; SB = 2'b11;
    wait_lights(6'b000000, 2'b11, "pro_green");
    skip(6); SB = 2'b00;
    wait_done(1'b1);
    PSB = 2'b00;
    wait_done(1'b0);
    skip(4);

    // Foul: lane 0 leaves during amber 1, lane 1 races on.
    push(6'b001001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b010010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b010000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b100000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 8);
    push(6'b000000, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b01, 2'b10, 1'b1, 1'b1, rtv(2, 65535), 1);
    push(6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 0);
    Mode = 1'b0; PSB = 2'b11; SB = 2'b11;
    wait_lights(6'b010010, 2'b00, "foul_amber1");
    SB[0] = 1'b0;
    wait_lights(6'b000000, 2'b10, "foul_green");
    skip(6); SB[1] = 1'b0;
    wait_done(1'b1);
    PSB = 2'b00;
    wait_done(1'b0);
    skip(4);

    // Early unstage after two staging ticks: no countdown may start.
    PSB = 2'b11; SB = 2'b11;
    skip(11); SB[1] = 1'b0;
    skip(2);  SB = 2'b00; PSB = 2'b00;
    skip(40);
    chk("unstage_amber", {26'd0, Amber}, 32'd0);
    chk("unstage_green_done", {29'd0, G, RaceDone}, 32'd0);

    // Reset during countdown, then restart from IDLE and foul both lanes.
    push(6'b001001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 0);
    push(6'b001001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 18);
    push(6'b000000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 32'd0, 0);
    push(6'b000000, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, rtv(65535, 65535), 1);
    push(6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 0);
    Mode = 1'b0; PSB = 2'b11; SB = 2'b11;
    wait_lights(6'b001001, 2'b00, "reset_amber0");
    skip(3);
    @(posedge Clock);
    #1 Rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    Rst = 1'b0;
    wait_lights(6'b001001, 2'b00, "restart_amber0");
    SB = 2'b00;
    wait_done(1'b1);
    PSB = 2'b00;
    wait_done(1'b0);
    skip(6);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
